// File: rtl/prime_job_scheduler.sv
// ============================================================================
// Module      : prime_job_scheduler
// Description : Round-robin scheduler sharing one prime-counting engine
//               between two requesters. Optional watchdog: PRIME_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prime_job_scheduler #(
  parameter int W           = 11,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [2*W-1:0]   req_num_max,
  output logic [1:0]       req_ready,
  output logic             eng_start,
  output logic [W-1:0]     eng_num_max,
  input  logic             eng_done,
  input  logic [W-1:0]     eng_count,
  output logic [1:0]       rsp_valid,
  output logic [W-1:0]     rsp_count,
  output logic             rsp_err,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_job;
  logic [W-1:0]     r_count;
  logic             r_grant;
  logic             r_last;
  logic [CNT_W-1:0] r_jobs;

  logic             w_pick;
  logic             w_accept;
  logic [W-1:0]     w_num_sel;
  logic             w_bypass;
  logic             w_tmo_hit;

  // Contention goes to whoever was not granted last; r_last resets to 1 so requester 0 wins first.
  assign w_pick    = req_valid[1] & (~req_valid[0] | ~r_last);
  assign w_accept  = (r_state == S_IDLE) & (|req_valid);
  assign w_num_sel = req_num_max[W*w_pick +: W];
  assign w_bypass  = (w_num_sel < W'(2));

`ifdef PRIME_SCHED_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_err;

  assign w_tmo_hit = (r_state == S_WAIT) & ~eng_done &
                     (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_tmo_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rsp_err = (r_state == S_REPORT) & r_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign w_tmo_hit    = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_job   <= '0;
      r_count <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_jobs  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_job   <= w_num_sel;
        r_grant <= w_pick;
        r_last  <= w_pick;
        r_count <= '0;
      end
      if (r_state == S_WAIT) begin
        if (eng_done) begin
          r_count <= eng_count;
        end else if (w_tmo_hit) begin
          r_count <= '1;
        end
      end
      if ((r_state == S_REPORT) && (r_jobs != {CNT_W{1'b1}})) begin
        r_jobs <= r_jobs + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    eng_start = 1'b0;
    rsp_valid = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready[w_pick] = 1'b1;
          w_next            = w_bypass ? S_REPORT : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || w_tmo_hit) begin
          w_next = S_REPORT;
        end
      end
      S_REPORT: begin
        rsp_valid[r_grant] = 1'b1;
        w_next             = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign eng_num_max = r_job;
  assign rsp_count   = (r_state == S_REPORT) ? r_count : '0;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;
  assign jobs_done   = r_jobs;

endmodule

`default_nettype wire

// File: tb/tb_prime_job_scheduler.sv
// ============================================================================
// Module      : tb_prime_job_scheduler
// Description : Scoreboard bench for prime_job_scheduler with a behavioural
//               prime-counting engine. Exercises PRIME_SCHED_TIMEOUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prime_job_scheduler;

  localparam int W     = 11;
  localparam int CNT_W = 16;
`ifdef PRIME_SCHED_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 4096;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [2*W-1:0]   req_num_max = '0;
  logic [1:0]       req_ready;
  logic             eng_start;
  logic [W-1:0]     eng_num_max;
  logic             eng_done = 1'b0;
  logic [W-1:0]     eng_count = '0;
  logic [1:0]       rsp_valid;
  logic [W-1:0]     rsp_count;
  logic             rsp_err;
  logic             busy;
  logic             grant_id;
  logic [CNT_W-1:0] jobs_done;

  always #5 clk = ~clk;

  prime_job_scheduler #(.W(W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_num_max(req_num_max), .req_ready(req_ready),
    .eng_start(eng_start), .eng_num_max(eng_num_max),
    .eng_done(eng_done), .eng_count(eng_count),
    .rsp_valid(rsp_valid), .rsp_count(rsp_count), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id), .jobs_done(jobs_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int primes_upto(input int n);
    int c;
    c = 0;
    for (int k = 2; k <= n; k++) begin
      bit p;
      p = 1'b1;
      for (int d = 2; d * d <= k; d++) if (k % d == 0) p = 1'b0;
      if (p) c++;
    end
    return c;
  endfunction

  typedef struct {
    logic         id;
    logic [W-1:0] cnt;
    logic         err;
    int           due;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  int   cyc = 0;
  int   exp_start_cyc = -1;
  int   exp_jobs = 0;
  bit   chk_jobs = 1'b0;
  bit   eng_hang = 1'b0;
  bit   start_seen = 1'b0;
  int   eng_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: done numMax+1 cycles after the start pulse; a new start restarts it.
  initial begin : engine
    bit active;
    int rem;
    active = 1'b0;
    rem    = 0;
    forever begin
      @(posedge clk);
      #2;
      eng_done = 1'b0;
      if (!rst) begin
        active     = 1'b0;
        start_seen = 1'b0;
      end else begin
        if (start_seen) begin
          start_seen = 1'b0;
          active     = !eng_hang;
          rem        = eng_n + 1;
        end
        if (active) begin
          rem--;
          if (rem == 0) begin
            eng_done  = 1'b1;
            eng_count = W'(primes_upto(eng_n));
            active    = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [1:0] acc;
    logic [1:0] exp_v;
    logic       id;
    int         n;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (req_ready != 2'b00) begin
          check("ready_onehot", $countones(req_ready), 1);
          check("ready_without_valid", {30'd0, req_ready & ~req_valid}, 0);
        end
        acc = req_valid & req_ready;
        if (acc != 2'b00) begin
          id    = acc[1];
          n     = int'(req_num_max[W*id +: W]);
          e.id  = id;
          if (n < 2) begin
            e.cnt = '0; e.err = 1'b0; e.due = cyc + 1;
            exp_start_cyc = -1;
          end else if (eng_hang || n >= TMO) begin
            e.cnt = '1; e.err = 1'b1; e.due = cyc + 2 + TMO;
            exp_start_cyc = cyc + 1;
          end else begin
            e.cnt = W'(primes_upto(n)); e.err = 1'b0; e.due = cyc + n + 3;
            exp_start_cyc = cyc + 1;
          end
          sb.push_back(e);
          grant_log.push_back(id);
        end
        if (eng_start || cyc == exp_start_cyc)
          check("eng_start", eng_start, cyc == exp_start_cyc);
        if (eng_start) begin
          start_seen = 1'b1;
          eng_n      = int'(eng_num_max);
        end
        if (chk_jobs) begin
          check("jobs_done", jobs_done, exp_jobs);
          chk_jobs = 1'b0;
        end
        if (sb.size() > 0 && (rsp_valid != 2'b00 || cyc >= sb[0].due)) begin
          e     = sb.pop_front();
          exp_v = e.id ? 2'b10 : 2'b01;
          check("rsp_valid", rsp_valid, exp_v);
          check("rsp_latency", cyc, e.due);
          if (rsp_valid != 2'b00) begin
            check("rsp_count", rsp_count, e.cnt);
            check("rsp_err", rsp_err, e.err);
            check("grant_id", grant_id, e.id);
          end
          exp_jobs++;
          chk_jobs = 1'b1;
        end else if (rsp_valid != 2'b00) begin
          check("rsp_unexpected", rsp_valid, 0);
        end
      end
    end
  end

  task automatic req_one(input int id, input int n);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_num_max[W*id +: W] = W'(n);
    req_valid[id] = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic req_both(input int n0, input int n1);
    logic [1:0] got;
    @(posedge clk); #1;
    req_num_max = {W'(n1), W'(n0)};
    req_valid   = 2'b11;
    for (int i = 0; i < 3000 && req_valid != 2'b00; i++) begin
      @(negedge clk);
      got = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~got;
    end
    if (req_valid != 2'b00) check("both_accept_timeout", 0, 1);
    req_valid = 2'b00;
  endtask

  task automatic req_fair(input int n0, input int n1, input int jobs);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    req_num_max = {W'(n1), W'(n0)};
    req_valid   = 2'b11;
    for (int i = 0; i < 5000 && cnt < jobs; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) cnt++;
    end
    if (cnt < jobs) check("fair_accept_timeout", cnt, jobs);
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_start_cyc = -1;
    exp_jobs      = 0;
    chk_jobs      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_jobs_done", jobs_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_eng_start", eng_start, 0);
    check("reset_eng_num_max", eng_num_max, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_count", rsp_count, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_jobs_done", jobs_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    req_one(0, 10);
    drain();
    check("single_jobs_done", jobs_done, 1);
    check("eng_num_max_hold", eng_num_max, 10);

    apply_reset();
    grant_log.delete();
    req_both(100, 30);
    drain();
    check("simul_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("simul_first", grant_log[0], 0);
      check("simul_second", grant_log[1], 1);
    end

    grant_log.delete();
    req_fair(5, 7, 6);
    drain();
    check("fair_grants", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) check("fair_order", grant_log[i], i % 2);

    req_one(1, 0);
    drain();
    req_one(1, 1);
    drain();
    check("bypass_eng_num_max", eng_num_max, 1);

    req_one(0, 50);
    repeat (3) @(posedge clk);
    check("mid_reset_in_wait", busy, 1);
    apply_reset();
    req_one(0, 2);
    drain();

`ifdef PRIME_SCHED_TIMEOUT_EN
    eng_hang = 1'b1;
    req_one(0, 10);
    drain();
    eng_hang = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
